pc_sequencer: RTL and testbench

// Program-counter stage directly upstream of the instruction memory: owns the PC, drives its
// 16-bit word address, and selects next PC from sequential, JMP/CALL/RET (decode) and taken

---
 rtl/isa_pkg.sv | 26 ++
 rtl/return_stack.sv | 50 +++++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode front end.
// Holds opcode constants, field widths, the return-stack request bundle
// and a sign-extension helper for the 5-bit branch immediate.
package isa_pkg;
  localparam int ADDR_W  = 16;
  localparam int IMM5_W  = 5;
  localparam int OFF12_W = 12;

  localparam logic [3:0] OP_BGT  = 4'b1000;
  localparam logic [3:0] OP_BLT  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_RET  = 4'b1110;

  typedef struct packed {
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] data;
  } ras_req_t;

  function automatic logic [ADDR_W-1:0] sext5(input logic [IMM5_W-1:0] imm);
    return {{(ADDR_W-IMM5_W){imm[IMM5_W-1]}}, imm};
  endfunction
endpackage

// File: rtl/return_stack.sv
// Circular return-address stack.
// Ports: clock/reset (sync, active-high); push/pop with push_data;
// top = most recently pushed entry; count/full/empty status.
// A push while full overwrites the oldest entry: the write pointer simply
// wraps onto it and count saturates at DEPTH. A pop while empty is ignored.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;     // next free slot
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   cnt;

  assign top_idx = ptr - PTR_W'(1);
  assign top     = mem[top_idx];
  assign count   = cnt;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
      cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[ptr] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding the instruction memory.
// Ports: clock/reset (sync, active-high); stall; decode-side id_jmp/id_call/
// id_ret with id_pc/id_offset; execute-side ex_br_taken with ex_pc/ex_imm.
// Outputs: AddressBus (current PC), if_valid (imem output live), id_flush
// (= ex_br_taken), sticky ras_overflow / ras_underflow.
// Next PC priority: reset > taken branch > decode redirect (unstalled) >
// stall hold > PC+1. Every redirect inserts one bubble on if_valid.
module pc_sequencer
  import isa_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter int                RAS_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               id_jmp,
  input  logic               id_call,
  input  logic               id_ret,
  input  logic [ADDR_W-1:0]  id_pc,
  input  logic [OFF12_W-1:0] id_offset,
  input  logic               ex_br_taken,
  input  logic [ADDR_W-1:0]  ex_pc,
  input  logic [IMM5_W-1:0]  ex_imm,
  output logic [ADDR_W-1:0]  AddressBus,
  output logic               if_valid,
  output logic               id_flush,
  output logic               ras_overflow,
  output logic               ras_underflow
);
  logic [ADDR_W-1:0] pc, next_pc, br_tgt, j_tgt, seq_ret;
  logic dec_ok, do_jmp, do_call, do_ret, redirect;
  logic [ADDR_W-1:0] ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic ras_full, ras_empty;
  ras_req_t ras_req;

  // A taken branch squashes decode, so decode-side control only acts when
  // neither a stall nor a branch redirect is present.
  assign dec_ok   = !stall && !ex_br_taken;
  assign do_jmp   = dec_ok && id_jmp;
  assign do_call  = dec_ok && id_call;
  assign do_ret   = dec_ok && id_ret;
  assign redirect = ex_br_taken || do_jmp || do_call || do_ret;

  assign br_tgt  = ex_pc + sext5(ex_imm);
  assign j_tgt   = {id_pc[ADDR_W-1:OFF12_W], id_offset};
  assign seq_ret = id_pc + 16'd1;

  assign ras_req.push = do_call;
  assign ras_req.pop  = do_ret && !ras_empty;
  assign ras_req.data = seq_ret;

  return_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_req.push),
    .pop       (ras_req.pop),
    .push_data (ras_req.data),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_comb begin
    next_pc = pc;
    if (ex_br_taken)            next_pc = br_tgt;
    else if (do_jmp || do_call) next_pc = j_tgt;
    else if (do_ret)            next_pc = ras_empty ? seq_ret : ras_top; // empty RET acts as NOP
    else if (!stall)            next_pc = pc + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_PC;
      if_valid      <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc <= next_pc;
      if (redirect)   if_valid <= 1'b0;
      else if (!stall) if_valid <= 1'b1;
      if (do_call && ras_full) ras_overflow  <= 1'b1;
      if (do_ret && ras_empty) ras_underflow <= 1'b1;
    end
  end

  assign AddressBus = pc;
  assign id_flush   = ex_br_taken;

  a_ras_cnt: assert property (@(posedge clock) disable iff (reset)
    ras_empty == (ras_count == '0));
  a_dec_1hot: assert property (@(posedge clock) disable iff (reset)
    $onehot0({id_jmp, id_call, id_ret}));
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset, stall, id_jmp, id_call, id_ret, ex_br_taken;
  logic [15:0] id_pc, ex_pc, AddressBus;
  logic [11:0] id_offset;
  logic [4:0]  ex_imm;
  logic if_valid, id_flush, ras_overflow, ras_underflow;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(16'h0000), .RAS_DEPTH(8)) dut (
    .clock(clk), .reset(reset), .stall(stall),
    .id_jmp(id_jmp), .id_call(id_call), .id_ret(id_ret),
    .id_pc(id_pc), .id_offset(id_offset),
    .ex_br_taken(ex_br_taken), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .AddressBus(AddressBus), .if_valid(if_valid), .id_flush(id_flush),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  // Behavioural model: PC as an integer, stack as a queue (oldest at front).
  logic [15:0] m_pc;
  logic        m_vld, m_ovf, m_unf, m_live = 1'b0;
  logic [15:0] mq[$];

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 16'h0000; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      mq.delete();
    end else begin
      bit redir;
      redir = 1'b0;
      if (ex_br_taken) begin
        m_pc = 16'(int'(ex_pc) + int'($signed(ex_imm)));
        redir = 1'b1;
      end else if (!stall && (id_jmp || id_call)) begin
        if (id_call) begin
          mq.push_back(16'(int'(id_pc) + 1));
          if (mq.size() > 8) begin
            void'(mq.pop_front());
            m_ovf = 1'b1;
          end
        end
        m_pc = {id_pc[15:12], id_offset};
        redir = 1'b1;
      end else if (!stall && id_ret) begin
        if (mq.size() == 0) begin
          m_unf = 1'b1;
          m_pc = 16'(int'(id_pc) + 1);
        end else m_pc = mq.pop_back();
        redir = 1'b1;
      end else if (!stall) m_pc = 16'(int'(m_pc) + 1);
      if (redir) m_vld = 1'b0;
      else if (!stall) m_vld = 1'b1;
    end
    m_live = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_addr",  32'(AddressBus),    32'(m_pc));
      chk("model_valid", 32'(if_valid),      32'(m_vld));
      chk("model_ovf",   32'(ras_overflow),  32'(m_ovf));
      chk("model_unf",   32'(ras_underflow), 32'(m_unf));
      chk("model_flush", 32'(id_flush),      32'(ex_br_taken));
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic idle();
    stall = 0; id_jmp = 0; id_call = 0; id_ret = 0; ex_br_taken = 0;
  endtask

  initial begin
    reset = 1; idle(); id_pc = 0; id_offset = 0; ex_pc = 0; ex_imm = 0;
    cyc();
    chk("rst_addr", 32'(AddressBus), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_flags", 32'({ras_overflow, ras_underflow}), 32'h0);
    reset = 0;
    // 1. sequential run
    cyc(); chk("seq1", 32'(AddressBus), 32'h1); chk("seq1_v", 32'(if_valid), 32'h1);
    cyc(); cyc(); cyc(); chk("seq4", 32'(AddressBus), 32'h4);
    // 2. stall holds
    stall = 1;
    for (int i = 0; i < 3; i++) cyc();
    chk("stall_addr", 32'(AddressBus), 32'h4); chk("stall_v", 32'(if_valid), 32'h1);
    stall = 0; cyc(); chk("unstall", 32'(AddressBus), 32'h5);
    // 3. JMP
    id_jmp = 1; id_pc = 16'h3005; id_offset = 12'd10; cyc();
    chk("jmp_addr", 32'(AddressBus), 32'h300A); chk("jmp_bubble", 32'(if_valid), 32'h0);
    idle(); cyc(); chk("jmp_next", 32'(AddressBus), 32'h300B); chk("jmp_v", 32'(if_valid), 32'h1);
    // 4. CALL then RET
    id_call = 1; id_pc = 16'd7; id_offset = 12'd20; cyc();
    chk("call_addr", 32'(AddressBus), 32'd20);
    idle(); cyc();
    id_ret = 1; id_pc = 16'd21; cyc();
    chk("ret_addr", 32'(AddressBus), 32'd8);
    chk("ret_flags", 32'({ras_overflow, ras_underflow}), 32'h0);
    idle(); cyc();
    // 5. branch beats a same-cycle CALL
    ex_br_taken = 1; ex_pc = 16'd9; ex_imm = 5'b11100; id_call = 1; id_pc = 16'h0700;
    #1 chk("flush_comb", 32'(id_flush), 32'h1);
    cyc(); chk("br_addr", 32'(AddressBus), 32'd5); chk("br_bubble", 32'(if_valid), 32'h0);
    idle();
    id_ret = 1; id_pc = 16'h0040; cyc();       // stack must still be empty
    chk("nopush_addr", 32'(AddressBus), 32'h41); chk("nopush_unf", 32'(ras_underflow), 32'h1);
    idle();
    // reset mid-sequence clears sticky state
    reset = 1; cyc(); reset = 0;
    chk("rst2_addr", 32'(AddressBus), 32'h0); chk("rst2_unf", 32'(ras_underflow), 32'h0);
    // wrap-around and stall interplay
    id_jmp = 1; id_pc = 16'hF000; id_offset = 12'hFFF; cyc();
    chk("jmp_ffff", 32'(AddressBus), 32'hFFFF);
    idle(); cyc(); chk("wrap0", 32'(AddressBus), 32'h0);
    stall = 1; ex_br_taken = 1; ex_pc = 16'd2; ex_imm = 5'b11100; id_jmp = 1; id_pc = 16'h5000;
    cyc(); chk("br_over_stall", 32'(AddressBus), 32'hFFFE);
    ex_br_taken = 0; cyc();
    chk("stall_ign_jmp", 32'(AddressBus), 32'hFFFE); chk("stall_hold_v0", 32'(if_valid), 32'h0);
    idle(); cyc(); chk("after_stall", 32'(AddressBus), 32'hFFFF); chk("after_stall_v", 32'(if_valid), 32'h1);
    // 6. overflow / underflow
    id_offset = 12'h800;
    for (int k = 0; k < 9; k++) begin
      id_call = 1; id_pc = 16'(16'h1000 + k * 16); cyc();
      chk("call_tgt", 32'(AddressBus), 32'h1800);
      if (k == 7) chk("ovf_before", 32'(ras_overflow), 32'h0);
    end
    chk("ovf_after", 32'(ras_overflow), 32'h1);
    idle();
    id_ret = 1; id_pc = 16'h2000;
    for (int i = 0; i < 8; i++) begin
      cyc(); chk("pop", 32'(AddressBus), 32'(16'h1001 + (8 - i) * 16));
    end
    chk("unf_before", 32'(ras_underflow), 32'h0);
    cyc();
    chk("pop9_addr", 32'(AddressBus), 32'h2001); chk("unf_after", 32'(ras_underflow), 32'h1);
    idle(); cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
